// File: rtl/sbus_frame_rx.sv
// SBUS receive front end: 8E2 deserialiser plus 25-byte frame assembler.
// Payload is presented as eleven little-endian words, with status flags and a saturating error count.
module sbus_frame_rx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 100000,
  parameter int INVERT     = 1,
  parameter int GAP_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  output logic [15:0] word0,
  output logic [15:0] word1,
  output logic [15:0] word2,
  output logic [15:0] word3,
  output logic [15:0] word4,
  output logic [15:0] word5,
  output logic [15:0] word6,
  output logic [15:0] word7,
  output logic [15:0] word8,
  output logic [15:0] word9,
  output logic [15:0] word10,
  output logic        ch17,
  output logic        ch18,
  output logic        frame_lost,
  output logic        failsafe,
  output logic        frame_valid,
  output logic [7:0]  err_cnt
);

  //  state     | meaning
  //  B_IDLE    | line idle, waiting for a start edge
  //  B_START   | half-bit wait, then glitch check of the start bit
  //  B_DATA    | eight data samples, LSB first
  //  B_PARITY  | even-parity sample
  //  B_STOP    | two stop samples, byte verdict on the second
  //  F_HUNT    | waiting for a 0x0F header that follows a full gap
  //  F_PAYLOAD | storing 22 payload bytes
  //  F_FLAGS   | storing the flags byte
  //  F_FOOTER  | 0x00 footer commits the frame, anything else aborts

  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int HALF    = BIT_CYC / 2;
  localparam int TW      = $clog2(BIT_CYC);
  localparam int GW      = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] BIT_LD  = TW'(BIT_CYC - 1);
  localparam logic [TW-1:0] HALF_LD = TW'(HALF - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES);
  localparam logic          RX_IDLE = (INVERT != 0) ? 1'b0 : 1'b1;

  typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_PARITY, B_STOP} bstate_t;
  typedef enum logic [1:0] {F_HUNT, F_PAYLOAD, F_FLAGS, F_FOOTER} fstate_t;

  bstate_t b_state, b_nxt;
  fstate_t f_state, f_nxt;

  logic [1:0]    rx_sync;
  logic          l, l_d, fall, tick;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_ok, stop1, byte_ok, byte_err, gap_ok;
  logic [GW-1:0] idle_cnt;
  logic          timeout, abort, commit, err_inc;
  logic [4:0]    idx;
  logic [7:0]    stage [22];
  logic [3:0]    flag_stage;
  logic [15:0]   words [11];

  assign l    = (INVERT != 0) ? ~rx_sync[1] : rx_sync[1];
  assign fall = l_d & ~l;
  assign tick = (timer == '0);

  always_comb begin
    b_nxt = b_state;
    case (b_state)
      B_IDLE:   if (fall) b_nxt = B_START;
      B_START:  if (tick) b_nxt = l ? B_IDLE : B_DATA;
      B_DATA:   if (tick && bit_idx == 3'd7) b_nxt = B_PARITY;
      B_PARITY: if (tick) b_nxt = B_STOP;
      B_STOP:   if (tick && bit_idx == 3'd1) b_nxt = B_IDLE;
      default:  b_nxt = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync  <= {2{RX_IDLE}};
      l_d      <= 1'b1;
      b_state  <= B_IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_ok   <= 1'b0;
      stop1    <= 1'b0;
      byte_ok  <= 1'b0;
      byte_err <= 1'b0;
      gap_ok   <= 1'b0;
      idle_cnt <= '0;
    end else begin
      rx_sync  <= {rx_sync[0], rx};
      l_d      <= l;
      b_state  <= b_nxt;
      byte_ok  <= 1'b0;
      byte_err <= 1'b0;
      if (b_state != B_IDLE && !tick) timer <= timer - 1'b1;
      case (b_state)
        B_IDLE: if (fall) begin
          timer  <= HALF_LD;
          gap_ok <= (idle_cnt == GAP_MAX);
        end
        B_START: if (tick) begin
          timer   <= BIT_LD;
          bit_idx <= '0;
        end
        B_DATA: if (tick) begin
          shreg   <= {l, shreg[7:1]};
          timer   <= BIT_LD;
          bit_idx <= bit_idx + 1'b1;
        end
        B_PARITY: if (tick) begin
          par_ok  <= ~(^{l, shreg});
          timer   <= BIT_LD;
          bit_idx <= '0;
        end
        B_STOP: if (tick) begin
          if (bit_idx == 3'd0) begin
            stop1   <= l;
            bit_idx <= 3'd1;
            timer   <= BIT_LD;
          end else if (par_ok && stop1 && l) begin
            byte_ok <= 1'b1;
          end else begin
            byte_err <= 1'b1;
          end
        end
        default: ;
      endcase
      // gap detector only runs between bytes; any start edge restarts it
      if (b_state == B_IDLE && fall) idle_cnt <= '0;
      else if (b_state == B_IDLE && l && idle_cnt != GAP_MAX) idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign timeout = (idle_cnt == GAP_MAX);

  always_comb begin
    f_nxt  = f_state;
    abort  = 1'b0;
    commit = 1'b0;
    case (f_state)
      F_HUNT:    if (byte_ok && shreg == 8'h0F && gap_ok) f_nxt = F_PAYLOAD;
      F_PAYLOAD: if (byte_err || timeout) abort = 1'b1;
                 else if (byte_ok && idx == 5'd21) f_nxt = F_FLAGS;
      F_FLAGS:   if (byte_err || timeout) abort = 1'b1;
                 else if (byte_ok) f_nxt = F_FOOTER;
      F_FOOTER:  if (byte_err || timeout) abort = 1'b1;
                 else if (byte_ok) begin
                   if (shreg == 8'h00) commit = 1'b1;
                   else abort = 1'b1;
                   f_nxt = F_HUNT;
                 end
      default:   f_nxt = F_HUNT;
    endcase
    if (abort) f_nxt = F_HUNT;
  end

  assign err_inc = abort | (f_state == F_HUNT && byte_err);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_state     <= F_HUNT;
      idx         <= '0;
      flag_stage  <= '0;
      frame_valid <= 1'b0;
      err_cnt     <= '0;
      {failsafe, frame_lost, ch18, ch17} <= '0;
      for (int i = 0; i < 22; i++) stage[i] <= '0;
      for (int k = 0; k < 11; k++) words[k] <= '0;
    end else begin
      f_state     <= f_nxt;
      frame_valid <= commit;
      if (f_state == F_HUNT) idx <= '0;
      if (f_state == F_PAYLOAD && byte_ok && !abort) begin
        stage[idx] <= shreg;
        idx        <= idx + 1'b1;
      end
      if (f_state == F_FLAGS && byte_ok && !abort) flag_stage <= shreg[3:0];
      if (commit) begin
        for (int k = 0; k < 11; k++) words[k] <= {stage[2*k+1], stage[2*k]};
        {failsafe, frame_lost, ch18, ch17} <= flag_stage;
      end
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end
  end

  assign word0  = words[0];
  assign word1  = words[1];
  assign word2  = words[2];
  assign word3  = words[3];
  assign word4  = words[4];
  assign word5  = words[5];
  assign word6  = words[6];
  assign word7  = words[7];
  assign word8  = words[8];
  assign word9  = words[9];
  assign word10 = words[10];

endmodule

// File: tb/tb_sbus_frame_rx.sv
// Directed bench for sbus_frame_rx: 1 MHz clock, 100 kbaud, 200-cycle gap, inverted line.
module tb_sbus_frame_rx;

  localparam int BITC = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx;
  logic [15:0] word [11];
  logic        ch17, ch18, frame_lost, failsafe, frame_valid;
  logic [7:0]  err_cnt;
  int          checks = 0;
  int          errors = 0;
  int          fv_cnt = 0;

  sbus_frame_rx #(.CLK_HZ(1000000), .BAUD(100000), .INVERT(1), .GAP_CYCLES(200)) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx),
    .word0(word[0]), .word1(word[1]), .word2(word[2]), .word3(word[3]),
    .word4(word[4]), .word5(word[5]), .word6(word[6]), .word7(word[7]),
    .word8(word[8]), .word9(word[9]), .word10(word[10]),
    .ch17(ch17), .ch18(ch18), .frame_lost(frame_lost), .failsafe(failsafe),
    .frame_valid(frame_valid), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_valid === 1'b1) fv_cnt++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive internal line level v (rx is its complement) for n clocks
  task automatic drive_l(input logic v, input int n);
    rx = ~v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    drive_l(1'b0, BITC);
    for (int i = 0; i < 8; i++) drive_l(b[i], BITC);
    drive_l((^b) ^ bad_par, BITC);
    drive_l(1'b1, BITC);
    drive_l(1'b1, BITC);
  endtask

  task automatic send_frame(input int pre, input logic [7:0] base, input logic [7:0] flg,
                            input logic [7:0] ftr, input int perr, input int npay);
    drive_l(1'b1, pre);
    send_byte(8'h0F, 1'b0);
    for (int i = 0; i < npay; i++) send_byte(base + 8'(i), i == perr);
    if (npay == 22) begin
      send_byte(flg, 1'b0);
      send_byte(ftr, 1'b0);
    end
    drive_l(1'b1, 20);
  endtask

  task automatic check_flags(input string tag, input logic [3:0] exp);
    check(tag, {12'h0, failsafe, frame_lost, ch18, ch17}, {12'h0, exp});
  endtask

  initial begin
    reset_n = 1'b0;
    rx      = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_word0", word[0], 16'h0000);
    check("rst_word10", word[10], 16'h0000);
    check_flags("rst_flags", 4'h0);
    check("rst_fv", {15'h0, frame_valid}, 16'h0000);
    check("rst_err", {8'h0, err_cnt}, 16'h0000);
    reset_n = 1'b1;

    // nominal frame
    send_frame(300, 8'h00, 8'h0C, 8'h00, -1, 22);
    check("nom_fv", 16'(fv_cnt), 16'd1);
    check("nom_word0", word[0], 16'h0100);
    check("nom_word5", word[5], 16'h0B0A);
    check("nom_word10", word[10], 16'h1514);
    check_flags("nom_flags", 4'hC);
    check("nom_err", {8'h0, err_cnt}, 16'd0);

    // parity error on payload byte 7
    send_frame(300, 8'h00, 8'h0C, 8'h00, 7, 22);
    check("par_fv", 16'(fv_cnt), 16'd1);
    check("par_err", {8'h0, err_cnt}, 16'd1);
    check("par_word0", word[0], 16'h0100);

    // clean frame after gap
    send_frame(300, 8'h20, 8'h03, 8'h00, -1, 22);
    check("clean_fv", 16'(fv_cnt), 16'd2);
    check("clean_word0", word[0], 16'h2120);
    check("clean_word10", word[10], 16'h3534);
    check_flags("clean_flags", 4'h3);

    // bad footer
    send_frame(300, 8'h40, 8'h0C, 8'h55, -1, 22);
    check("ftr_fv", 16'(fv_cnt), 16'd2);
    check("ftr_err", {8'h0, err_cnt}, 16'd2);
    check("ftr_word0", word[0], 16'h2120);

    // header only 2 bit-times after previous byte
    send_frame(0, 8'h60, 8'h0C, 8'h00, -1, 22);
    check("nogap_fv", 16'(fv_cnt), 16'd2);
    check("nogap_err", {8'h0, err_cnt}, 16'd2);
    check("nogap_word0", word[0], 16'h2120);

    // inter-byte timeout after payload byte 10, then a frame right behind the gap
    send_frame(300, 8'h00, 8'h0C, 8'h00, -1, 11);
    drive_l(1'b1, 230);
    check("tmo_err", {8'h0, err_cnt}, 16'd3);
    check("tmo_fv", 16'(fv_cnt), 16'd2);
    send_frame(0, 8'h80, 8'h0C, 8'h00, -1, 22);
    check("tmo_next_fv", 16'(fv_cnt), 16'd3);
    check("tmo_next_word0", word[0], 16'h8180);
    check("tmo_next_word10", word[10], 16'h9594);

    // glitch restarts the gap: a header 100 cycles later is not framed
    drive_l(1'b1, 300);
    drive_l(1'b0, 3);
    send_frame(100, 8'hA0, 8'h0C, 8'h00, -1, 22);
    check("glitch_fv", 16'(fv_cnt), 16'd3);
    check("glitch_err", {8'h0, err_cnt}, 16'd3);
    check("glitch_word0", word[0], 16'h8180);
    send_frame(300, 8'hC0, 8'h04, 8'h00, -1, 22);
    check("glitch_next_fv", 16'(fv_cnt), 16'd4);
    check("glitch_next_word0", word[0], 16'hC1C0);
    check_flags("glitch_next_flags", 4'h4);

    // reset during payload byte 12
    send_frame(300, 8'hE0, 8'h0C, 8'h00, -1, 12);
    drive_l(1'b0, BITC);
    drive_l(1'b1, BITC);
    drive_l(1'b0, 5);
    reset_n = 1'b0;
    #1;
    check("mrst_word0", word[0], 16'h0000);
    check("mrst_word5", word[5], 16'h0000);
    check_flags("mrst_flags", 4'h0);
    check("mrst_err", {8'h0, err_cnt}, 16'd0);
    drive_l(1'b1, 5);
    reset_n = 1'b1;
    send_frame(300, 8'h00, 8'h0C, 8'h00, -1, 22);
    check("mrst_next_fv", 16'(fv_cnt), 16'd5);
    check("mrst_next_word0", word[0], 16'h0100);
    check("mrst_next_word5", word[5], 16'h0B0A);

    // error counter saturation
    for (int n = 0; n < 300; n++) begin
      send_byte(8'h55, 1'b1);
      drive_l(1'b1, 3);
    end
    check("sat_err", {8'h0, err_cnt}, 16'd255);
    check("sat_fv", 16'(fv_cnt), 16'd5);
    check("sat_word0", word[0], 16'h0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
